alu_rr_scheduler: RTL and testbench

- Shares one ALU instance between NUM_REQ independent requesters.
- Uses round-robin arbitration with one operation in flight at a time.
- Sequences the ALU's valid/command/size/operand inputs and honours the extra latency of the clocked 16x16 multiplier.
- Returns the registered result/signal pair to the granted requester with a response handshake; sits between the issue logic and the ALU.

---
 rtl/alu_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one ALU between NUM_REQ requesters, one op in flight,
// holding operands stable for the multiplier pipeline before strobing alu_valid.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | no op in flight; grant the next requester round-robin
//  S_WAIT  | multiply: operands on the ALU, alu_valid low, timer counting down
//  S_ISSUE | alu_valid high for one cycle
//  S_RESP  | response presented until rsp_ready
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [3*NUM_REQ-1:0]       req_cmd,
    input  logic [NUM_REQ-1:0]         req_size,
    input  logic [32*NUM_REQ-1:0]      req_a,
    input  logic [32*NUM_REQ-1:0]      req_b,
    output logic                       alu_valid,
    output logic [2:0]                 alu_command,
    output logic                       alu_size,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    input  logic [31:0]                alu_result,
    input  logic [1:0]                 alu_signal,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                rsp_result,
    output logic [1:0]                 rsp_signal,
    output logic                       rsp_err,
    output logic [15:0]                op_count
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [2:0] CMD_MUL = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic [2:0]        grant_cmd;
    logic              grant_size;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_cmd;
    logic              op_size;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic [ID_W-1:0]   op_id;
    logic              op_err;

    // Walk forward from the last winner, wrapping at NUM_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign grant_cmd  = req_cmd[grant_id*3 +: 3];
    assign grant_size = req_size[grant_id];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found)
                         state_nxt = (grant_cmd == CMD_MUL && MUL_LAT > 0) ? S_WAIT : S_ISSUE;
            S_WAIT:  if (cnt == '0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        alu_valid = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE:  if (grant_found) req_ready[grant_id] = 1'b1;
            S_ISSUE: alu_valid = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Op registers only change on a grant, so the ALU inputs hold between ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= ID_W'(NUM_REQ - 1);
            cnt      <= '0;
            op_cmd   <= '0;
            op_size  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
            op_err   <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (grant_found) begin
                    ptr     <= grant_id;
                    op_cmd  <= grant_cmd;
                    op_size <= grant_size;
                    op_a    <= req_a[grant_id*32 +: 32];
                    op_b    <= req_b[grant_id*32 +: 32];
                    op_id   <= grant_id;
                    op_err  <= (grant_cmd == CMD_MUL) && grant_size;
                    cnt     <= CNT_W'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);
                end
                S_WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                S_RESP: if (rsp_ready && op_count != 16'hffff) op_count <= op_count + 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_command = op_cmd;
    assign alu_size    = op_size;
    assign alu_a       = op_a;
    assign alu_b       = op_b;
    assign rsp_id      = op_id;
    assign rsp_err     = op_err;
    assign rsp_result  = alu_result;
    assign rsp_signal  = alu_signal;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a small registered ALU stand-in:
// cmd 0 add {ovf,carry}, cmd 1 sub {ovf,borrow}, cmd 6 16x16 mul (size 1 -> 0), others a^b.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [3*NUM_REQ-1:0]  req_cmd;
    logic [NUM_REQ-1:0]    req_size;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  alu_valid;
    logic [2:0]            alu_command;
    logic                  alu_size;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [31:0]           alu_result;
    logic [1:0]            alu_signal;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [31:0]           rsp_result;
    logic [1:0]            rsp_signal;
    logic                  rsp_err;
    logic [15:0]           op_count;

    int vectors = 0;
    int miscompares = 0;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_size(req_size),
        .req_a(req_a), .req_b(req_b),
        .alu_valid(alu_valid), .alu_command(alu_command), .alu_size(alu_size),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_signal(alu_signal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_signal(rsp_signal), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] alu_model(input logic [2:0] c, input logic s,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s33;
        logic [16:0] s17;
        logic [31:0] r;
        logic        ovf;
        logic        cy;
        r = a ^ b; ovf = 1'b0; cy = 1'b0;
        case (c)
            3'd0: if (s) begin
                      s33 = {1'b0, a} + {1'b0, b};
                      r = s33[31:0]; cy = s33[32];
                      ovf = (a[31] == b[31]) && (r[31] != a[31]);
                  end else begin
                      s17 = {1'b0, a[15:0]} + {1'b0, b[15:0]};
                      r = {16'h0, s17[15:0]}; cy = s17[16];
                      ovf = (a[15] == b[15]) && (r[15] != a[15]);
                  end
            3'd1: begin
                      r = a - b; cy = (a < b);
                      ovf = (a[31] != b[31]) && (r[31] != a[31]);
                  end
            3'd6: r = s ? 32'h0 : a[15:0] * b[15:0];
            default: ;
        endcase
        return {ovf, cy, r};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= '0;
            alu_signal <= '0;
        end else if (alu_valid) begin
            {alu_signal, alu_result} <= alu_model(alu_command, alu_size, alu_a, alu_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        req_cmd[3*i +: 3]  = c;
        req_size[i]        = s;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_cmd = '0; req_size = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        sample();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_alu_command", alu_command, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_op_count", op_count, 0);

        // Single 32-bit add overflowing into the sign bit
        step(); set_req(0, 3'd0, 1'b1, 32'h7fff_ffff, 32'h1); req_valid = 4'b0001; sample();
        chk("t1_grant", req_ready, 4'b0001);
        step(); req_valid = '0; sample();
        chk("t1_alu_valid", alu_valid, 1);
        chk("t1_alu_a", alu_a, 32'h7fff_ffff);
        chk("t1_alu_b", alu_b, 32'h1);
        chk("t1_alu_size", alu_size, 1);
        chk("t1_no_rsp_yet", rsp_valid, 0);
        step(); sample();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_result", rsp_result, 32'h8000_0000);
        chk("t1_rsp_signal", rsp_signal, 2'b10);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_err", rsp_err, 0);
        step(); sample();
        chk("t1_op_count", op_count, 1);
        chk("t1_rsp_drop", rsp_valid, 0);

        // Reset, then all four requesters continuously: grants 0,1,2,3,0 three cycles apart
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd0, 1'b1, 32'd100 + 32'(i), 32'(i));
        req_valid = 4'hf;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            sample();
            if (k == 0) chk("t2_op_count_cleared", op_count, 0);
            chk("t2_req_ready", req_ready, (k % 3 == 0) ? 32'(1 << ((k / 3) % 4)) : 32'd0);
            if (k % 3 == 2) begin
                chk("t2_rsp_valid", rsp_valid, 1);
                chk("t2_rsp_id", rsp_id, 32'((k / 3) % 4));
                chk("t2_rsp_result", rsp_result, 32'd100 + 32'(2 * ((k / 3) % 4)));
            end
        end
        step(); req_valid = '0; sample();
        chk("t2_op_count", op_count, 5);
        chk("t2_rsp_drop", rsp_valid, 0);

        // Multiply on requester 2: operands held through two WAIT cycles then ISSUE
        step(); set_req(2, 3'd6, 1'b0, 32'h3, 32'h5); req_valid = 4'b0100; sample();
        chk("t3_grant", req_ready, 4'b0100);
        step(); req_valid = '0; sample();
        chk("t3_wait1_valid", alu_valid, 0);
        chk("t3_wait1_cmd", alu_command, 6);
        chk("t3_wait1_a", alu_a, 3);
        chk("t3_wait1_b", alu_b, 5);
        step(); sample();
        chk("t3_wait2_valid", alu_valid, 0);
        chk("t3_wait2_a", alu_a, 3);
        chk("t3_wait2_b", alu_b, 5);
        step(); sample();
        chk("t3_issue_valid", alu_valid, 1);
        chk("t3_issue_a", alu_a, 3);
        chk("t3_issue_b", alu_b, 5);
        chk("t3_no_rsp_yet", rsp_valid, 0);
        step(); sample();
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_result", rsp_result, 15);
        chk("t3_rsp_signal", rsp_signal, 0);
        chk("t3_rsp_id", rsp_id, 2);
        chk("t3_rsp_err", rsp_err, 0);

        // Backpressure with requester 1 pending
        step(); set_req(3, 3'd1, 1'b1, 32'd10, 32'd3); req_valid = 4'b1000; rsp_ready = 1'b0; sample();
        chk("t4_grant3", req_ready, 4'b1000);
        step(); set_req(1, 3'd0, 1'b1, 32'd20, 32'd22); req_valid = 4'b0010; sample();
        chk("t4_issue_valid", alu_valid, 1);
        chk("t4_issue_no_grant", req_ready, 0);
        for (int k = 0; k < 10; k++) begin
            step(); sample();
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_result", rsp_result, 7);
            chk("t4_hold_id", rsp_id, 3);
            chk("t4_hold_no_grant", req_ready, 0);
        end
        step(); rsp_ready = 1'b1; sample();
        chk("t4_hs_valid", rsp_valid, 1);
        chk("t4_hs_no_grant", req_ready, 0);
        step(); sample();
        chk("t4_grant1", req_ready, 4'b0010);
        chk("t4_op_count", op_count, 7);
        chk("t4_rsp_drop", rsp_valid, 0);
        step(); req_valid = '0; sample();
        chk("t4_issue1_a", alu_a, 20);
        step(); sample();
        chk("t4_rsp1_result", rsp_result, 42);
        chk("t4_rsp1_id", rsp_id, 1);

        // Illegal 32-bit multiply, then a legal 16-bit add
        step(); set_req(0, 3'd6, 1'b1, 32'h3, 32'h5); req_valid = 4'b0001; sample();
        chk("t5_grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        step();
        step(); sample();
        chk("t5_issue_valid", alu_valid, 1);
        step(); sample();
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_result", rsp_result, 0);
        chk("t5_rsp_signal", rsp_signal, 0);
        step(); set_req(1, 3'd0, 1'b0, 32'd1, 32'd2); req_valid = 4'b0010; sample();
        chk("t5_grant_next", req_ready, 4'b0010);
        step(); req_valid = '0;
        step(); sample();
        chk("t5_next_valid", rsp_valid, 1);
        chk("t5_next_err", rsp_err, 0);
        chk("t5_next_result", rsp_result, 3);
        chk("t5_next_id", rsp_id, 1);

        // Reset during WAIT drops the op and re-arms the pointer
        step(); set_req(2, 3'd6, 1'b0, 32'h2, 32'h2); req_valid = 4'b0100; sample();
        chk("t6_grant", req_ready, 4'b0100);
        step(); req_valid = '0; reset = 1'b1; sample();
        chk("t6_wait_valid", alu_valid, 0);
        chk("t6_wait_cmd", alu_command, 6);
        step(); reset = 1'b0;
        set_req(0, 3'd0, 1'b1, 32'd5, 32'd6);
        set_req(3, 3'd0, 1'b1, 32'd1, 32'd1);
        req_valid = 4'b1001; sample();
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_op_count", op_count, 0);
        chk("t6_alu_valid", alu_valid, 0);
        chk("t6_alu_cmd_cleared", alu_command, 0);
        chk("t6_grant0", req_ready, 4'b0001);
        step(); req_valid = 4'b1000; sample();
        chk("t6_issue_valid", alu_valid, 1);
        chk("t6_issue_a", alu_a, 5);
        step(); sample();
        chk("t6_rsp_id", rsp_id, 0);
        chk("t6_rsp_result", rsp_result, 11);
        step(); sample();
        chk("t6_grant3", req_ready, 4'b1000);
        chk("t6_op_count_after", op_count, 1);
        step(); req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
